// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, samples each bit at mid-bit,
// checks the stop bit and presents each recovered word on a valid/ready port.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_sig,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W      = $clog2(PULSE_WIDTH);
    localparam int IDX_W       = $clog2(DATA_WIDTH + 1);
    localparam int SYNC_STAGES = 2;

    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(PULSE_WIDTH / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(PULSE_WIDTH - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Synchroniser chain: tap 0 is the raw pin, the last tap is rx_s.
    wire [SYNC_STAGES:0] sync_tap;
    logic                rx_s;

    assign sync_tap[0] = rx_sig;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi = gi + 1) begin : g_sync
            logic stage_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= 1'b1;
                end else begin
                    stage_reg <= sync_tap[gi];
                end
            end

            assign sync_tap[gi+1] = stage_reg;
        end
    endgenerate

    assign rx_s = sync_tap[SYNC_STAGES];

    state_t                  state_reg,     state_next;
    logic [BAUD_W-1:0]       baud_cnt_reg,  baud_cnt_next;
    logic [IDX_W-1:0]        bit_idx_reg,   bit_idx_next;
    logic [DATA_WIDTH-1:0]   shift_reg,     shift_next;
    logic                    prev_reg;
    logic [DATA_WIDTH-1:0]   data_reg,      data_next;
    logic                    valid_reg,     valid_next;
    logic                    frame_err_reg, frame_err_next;
    logic                    overrun_reg,   overrun_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            baud_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            prev_reg      <= 1'b1;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            baud_cnt_reg  <= baud_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            prev_reg      <= rx_s;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        baud_cnt_next  = baud_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;

        // A consumed word frees the slot; a load below on the same edge wins.
        if (valid_reg && ready) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (prev_reg && !rx_s) begin
                    state_next    = START;
                    baud_cnt_next = '0;
                end
            end

            START: begin
                if (baud_cnt_reg == HALF_LAST) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = rx_s ? IDLE : DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_ONE;
                end
            end

            DATA: begin
                if (baud_cnt_reg == FULL_LAST) begin
                    // LSB arrives first, so after DATA_WIDTH shifts it sits at bit 0.
                    shift_next    = {rx_s, shift_reg[DATA_WIDTH-1:1]};
                    baud_cnt_next = '0;
                    bit_idx_next  = bit_idx_reg + IDX_ONE;
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_ONE;
                end
            end

            STOP: begin
                if (baud_cnt_reg == FULL_LAST) begin
                    // Leave at mid stop bit so an immediately following start edge is seen.
                    state_next    = IDLE;
                    baud_cnt_next = '0;
                    if (!rx_s) begin
                        frame_err_next = 1'b1;
                    end else if (!valid_reg || ready) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end else begin
                        overrun_next = 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_ONE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-built corner
// sequences and randomised traffic scored against a word-slot model.
module tb_uart_rx;

    localparam int DW       = 8;
    localparam int BAUD     = 115200;
    localparam int CLK_FREQ = 1_152_000;
    localparam int PW       = CLK_FREQ / BAUD;
    // Cycles from the start-bit edge at the pin to the edge that loads the word.
    localparam int LOAD_LAT = PW * (DW + 1) + PW / 2 + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_sig = 1'b1;
    logic          ready = 1'b0;
    logic [DW-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          overrun;

    uart_rx #(
        .DATA_WIDTH(DW),
        .BAUD_RATE (BAUD),
        .CLK_FREQ  (CLK_FREQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_sig   (rx_sig),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [DW-1:0] got_q[$];

    // Consumer-side monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (valid && ready) got_q.push_back(data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] b, input logic stop, input int low_hold);
        rx_sig = 1'b0;
        tick(PW);
        for (int i = 0; i < DW; i++) begin
            rx_sig = b[i];
            tick(PW);
        end
        rx_sig = stop;
        tick(PW);
        if (!stop) tick(low_hold);
        rx_sig = 1'b1;
    endtask

    typedef struct {
        logic [DW-1:0] payload;
        logic          stop;
        logic          rdy;
        logic [DW-1:0] exp_data;
        logic          exp_valid;
        int            exp_fe;
        int            exp_ov;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int fe0, ov0;
        logic [DW-1:0] exp_q[$];
        logic          occ;
        logic [DW-1:0] slot;
        int            exp_fe, exp_ov;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 0, 0};
        vecs[1] = '{8'h55, 1'b0, 1'b1, 8'hA5, 1'b0, 1, 0};
        vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 0, 0};
        vecs[3] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};
        vecs[4] = '{8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 0, 1};
        vecs[5] = '{8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 0, 0};

        // Reset with a toggling line.
        for (int i = 0; i < 5; i++) begin
            rx_sig = i[0];
            tick(1);
        end
        rx_sig = 1'b1;
        tick(3);
        chk("reset data", data, 0);
        chk("reset valid", valid, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overrun", overrun, 0);
        rst = 1'b0;
        tick(2000);
        chk("idle no transfer", got_q.size(), 0);
        chk("idle valid", valid, 0);
        chk("idle no pulses", fe_cnt + ov_cnt, 0);

        // Table-driven frames; state carries from one vector to the next.
        for (int i = 0; i < 6; i++) begin
            ready = vecs[i].rdy;
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send_frame(vecs[i].payload, vecs[i].stop, 0);
            tick(2 * PW);
            chk($sformatf("vec%0d data", i), data, vecs[i].exp_data);
            chk($sformatf("vec%0d valid", i), valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
            chk($sformatf("vec%0d overrun", i), ov_cnt - ov0, vecs[i].exp_ov);
        end

        // Back-to-back sweep of every byte value.
        ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1, 0);
        tick(2 * PW);
        chk("sweep count", got_q.size(), 256);
        for (int i = 0; i < 256; i++) chk($sformatf("sweep %0d", i), got_q[i], i);

        // Short glitch must be rejected.
        got_q.delete();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx_sig = 1'b0;
        tick(3);
        rx_sig = 1'b1;
        tick(3 * PW);
        chk("glitch no transfer", got_q.size(), 0);
        chk("glitch no pulse", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        send_frame(8'h3C, 1'b1, 0);
        tick(2 * PW);
        chk("after glitch data", data, 8'h3C);
        chk("after glitch count", got_q.size(), 1);

        // Framing error with a long low line afterwards.
        got_q.delete();
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 200);
        tick(2 * PW);
        chk("ferr pulse cycles", fe_cnt - fe0, 1);
        chk("ferr valid", valid, 0);
        chk("ferr no transfer", got_q.size(), 0);
        send_frame(8'h81, 1'b1, 0);
        tick(2 * PW);
        chk("after ferr data", data, 8'h81);
        chk("after ferr no retrigger", fe_cnt - fe0, 1);

        // Consume and load on the same edge.
        ready = 1'b0;
        got_q.delete();
        ov0 = ov_cnt;
        send_frame(8'h44, 1'b1, 0);
        tick(PW);
        chk("held valid", valid, 1);
        chk("held data", data, 8'h44);
        fork
            send_frame(8'h33, 1'b1, 0);
            begin
                tick(LOAD_LAT - 1);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
            end
        join
        tick(2 * PW);
        chk("simul data", data, 8'h33);
        chk("simul valid", valid, 1);
        chk("simul overrun", ov_cnt - ov0, 0);
        chk("simul consumed old", got_q[0], 8'h44);
        ready = 1'b1;
        tick(2);
        chk("simul drained", got_q.size(), 2);

        // Reset in the middle of data bit 4.
        got_q.delete();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        fork
            send_frame(8'hF5, 1'b1, 0);
            begin
                tick(5 * PW + PW / 2);
                rst = 1'b1;
                tick(3);
                rst = 1'b0;
            end
        join
        tick(2 * PW);
        chk("midrst valid", valid, 0);
        chk("midrst data", data, 0);
        chk("midrst no pulse", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        send_frame(8'h7E, 1'b1, 0);
        tick(2 * PW);
        chk("after midrst data", data, 8'h7E);
        chk("after midrst count", got_q.size(), 1);

        // Randomised traffic against a one-word slot model.
        got_q.delete();
        exp_q.delete();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        exp_fe = 0;
        exp_ov = 0;
        occ = 1'b0;
        slot = '0;
        for (int n = 0; n < 40; n++) begin
            logic r, stop;
            logic [DW-1:0] b;
            int gap;
            r = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 5) != 0);
            b = DW'($urandom);
            gap = stop ? int'($urandom_range(0, 2 * PW)) : PW + int'($urandom_range(0, PW));
            ready = r;
            if (occ && r) begin
                exp_q.push_back(slot);
                occ = 1'b0;
            end
            send_frame(b, stop, 0);
            tick(gap);
            if (!stop) begin
                exp_fe++;
            end else if (!occ) begin
                if (r) exp_q.push_back(b);
                else begin
                    occ = 1'b1;
                    slot = b;
                end
            end else begin
                exp_ov++;
            end
        end
        ready = 1'b1;
        if (occ) exp_q.push_back(slot);
        tick(2 * PW);
        chk("rand count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) chk($sformatf("rand word %0d", i), got_q[i], exp_q[i]);
        chk("rand frame_err", fe_cnt - fe0, exp_fe);
        chk("rand overrun", ov_cnt - ov0, exp_ov);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
